// File: rtl/sonar_pkg.sv
// rtl/sonar_pkg.sv - Shared state encoding, default timing constants and pin mode codes for the sonar ping sequencer
package sonar_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CFG_TRIG  = 3'd1,
    CFG_ECHO  = 3'd2,
    TRIG_HI   = 3'd3,
    TRIG_LO   = 3'd4,
    WAIT_RISE = 3'd5,
    MEASURE   = 3'd6,
    DONE      = 3'd7
  } state_t;

  // 10 us trigger, 30 ms echo window, 60 ms auto-ping interval at 50 MHz
  localparam int TRIG_CYCLES_DEF    = 500;
  localparam int TIMEOUT_CYCLES_DEF = 1500000;
  localparam int PING_PERIOD_DEF    = 3000000;

  localparam logic MODE_IN  = 1'b0;
  localparam logic MODE_OUT = 1'b1;

endpackage

// File: rtl/sonar_ping_ctrl_if.sv
// rtl/sonar_ping_ctrl_if.sv - Request/result and GPIO-bank signal bundle; SONAR_AUTOPING_EN adds auto_en
interface sonar_ping_ctrl_if #(
  parameter int CNT_W = 24
);
  logic             start;
  logic [2:0]       trig_sel;
  logic [2:0]       echo_sel;
`ifdef SONAR_AUTOPING_EN
  logic             auto_en;
`endif
  logic [7:0]       pins_in;
  logic [2:0]       pin_num;
  logic             pin_data;
  logic             val_we;
  logic             mode_we;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] echo_width;

`ifdef SONAR_AUTOPING_EN
  modport master (
    output start, trig_sel, echo_sel, auto_en, pins_in,
    input  pin_num, pin_data, val_we, mode_we, busy, done, timeout, echo_width
  );
  modport slave (
    input  start, trig_sel, echo_sel, auto_en, pins_in,
    output pin_num, pin_data, val_we, mode_we, busy, done, timeout, echo_width
  );
`else
  modport master (
    output start, trig_sel, echo_sel, pins_in,
    input  pin_num, pin_data, val_we, mode_we, busy, done, timeout, echo_width
  );
  modport slave (
    input  start, trig_sel, echo_sel, pins_in,
    output pin_num, pin_data, val_we, mode_we, busy, done, timeout, echo_width
  );
`endif
endinterface

// File: rtl/sonar_sync2.sv
// rtl/sonar_sync2.sv - Two-flop synchroniser with asynchronous active-low reset
module sonar_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/sonar_ping_ctrl.sv
// rtl/sonar_ping_ctrl.sv - Ultrasonic ping sequencer owning the GPIO bank; macro SONAR_AUTOPING_EN adds periodic auto-ping
module sonar_ping_ctrl
  import sonar_pkg::*;
#(
  parameter int CNT_W          = 24,
  parameter int TRIG_CYCLES    = TRIG_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`ifdef SONAR_AUTOPING_EN
  ,
  parameter int PING_PERIOD    = PING_PERIOD_DEF
`endif
) (
  input  logic             clk,
  input  logic             reset,
  sonar_ping_ctrl_if.slave bus
);
  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_n;
  logic [2:0]       trig_q, trig_n, echo_q, echo_n;
  logic [CNT_W-1:0] cnt, cnt_n, tmo, tmo_n, width, width_n;
  logic             timeout_q;
  logic [CNT_W-1:0] width_q;
  logic             res_load, res_timeout;
  logic [CNT_W-1:0] res_width;
  logic             start_req, start_acc, echo_s;
  logic [2:0]       pin_num_c;
  logic             pin_data_c, val_we_c, mode_we_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  sonar_sync2 u_echo_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (bus.pins_in[echo_q]),
    .q     (echo_s)
  );

`ifdef SONAR_AUTOPING_EN
  // Wide enough to hold PING_PERIOD even when CNT_W is narrow
  localparam int PW = ($clog2(PING_PERIOD + 1) > CNT_W) ? $clog2(PING_PERIOD + 1) : CNT_W;
  localparam logic [PW-1:0] PERIOD_LAST = PW'(PING_PERIOD - 1);

  logic [PW-1:0] period_cnt;
  logic          auto_req;

  // Holding at PERIOD_LAST keeps the request pending until IDLE accepts it
  assign auto_req  = bus.auto_en && (period_cnt == PERIOD_LAST);
  assign start_req = bus.start || auto_req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_cnt <= '0;
    end else if (start_acc || !bus.auto_en) begin
      period_cnt <= '0;
    end else if (period_cnt != PERIOD_LAST) begin
      period_cnt <= period_cnt + PW'(1);
    end
  end
`else
  assign start_req = bus.start;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      trig_q    <= '0;
      echo_q    <= '0;
      cnt       <= '0;
      tmo       <= '0;
      width     <= '0;
      timeout_q <= 1'b0;
      width_q   <= '0;
    end else begin
      state  <= state_n;
      trig_q <= trig_n;
      echo_q <= echo_n;
      cnt    <= cnt_n;
      tmo    <= tmo_n;
      width  <= width_n;
      if (res_load) begin
        timeout_q <= res_timeout;
        width_q   <= res_width;
      end
    end
  end

  always_comb begin
    state_n     = state;
    trig_n      = trig_q;
    echo_n      = echo_q;
    cnt_n       = cnt;
    tmo_n       = tmo;
    width_n     = width;
    start_acc   = 1'b0;
    res_load    = 1'b0;
    res_timeout = 1'b0;
    res_width   = '0;
    pin_num_c   = '0;
    pin_data_c  = 1'b0;
    val_we_c    = 1'b0;
    mode_we_c   = 1'b0;
    case (state)
      IDLE: begin
        if (start_req) begin
          start_acc = 1'b1;
          trig_n    = bus.trig_sel;
          echo_n    = bus.echo_sel;
          cnt_n     = '0;
          tmo_n     = '0;
          width_n   = '0;
          if (bus.trig_sel == bus.echo_sel) begin
            state_n     = DONE;
            res_load    = 1'b1;
            res_timeout = 1'b1;
          end else begin
            state_n = CFG_TRIG;
          end
        end
      end
      CFG_TRIG: begin
        pin_num_c  = trig_q;
        pin_data_c = MODE_OUT;
        mode_we_c  = 1'b1;
        state_n    = CFG_ECHO;
      end
      CFG_ECHO: begin
        pin_num_c  = echo_q;
        pin_data_c = MODE_IN;
        mode_we_c  = 1'b1;
        state_n    = TRIG_HI;
      end
      TRIG_HI: begin
        if (cnt == '0) begin
          pin_num_c  = trig_q;
          pin_data_c = 1'b1;
          val_we_c   = 1'b1;
        end
        if (cnt == TRIG_LAST) state_n = TRIG_LO;
        else                  cnt_n   = sat_inc(cnt);
      end
      TRIG_LO: begin
        pin_num_c = trig_q;
        val_we_c  = 1'b1;
        state_n   = WAIT_RISE;
      end
      WAIT_RISE: begin
        tmo_n = sat_inc(tmo);
        if (tmo == TMO_LAST) begin
          state_n     = DONE;
          res_load    = 1'b1;
          res_timeout = 1'b1;
        end else if (echo_s) begin
          state_n = MEASURE;
          width_n = CNT_W'(1);
        end
      end
      MEASURE: begin
        tmo_n = sat_inc(tmo);
        // A falling echo beats a coincident timeout
        if (!echo_s) begin
          state_n   = DONE;
          res_load  = 1'b1;
          res_width = width;
        end else if (tmo == TMO_LAST) begin
          state_n     = DONE;
          res_load    = 1'b1;
          res_timeout = 1'b1;
        end else begin
          width_n = sat_inc(width);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.pin_num    = pin_num_c;
  assign bus.pin_data   = pin_data_c;
  assign bus.val_we     = val_we_c;
  assign bus.mode_we    = mode_we_c;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.timeout    = timeout_q;
  assign bus.echo_width = width_q;
endmodule

// File: doc/sonar_ping_ctrl.md
Name: sonar_ping_ctrl

Overview:
- Sequencer that owns the shared 8-pin GPIO bank (io_pin_set) for one ultrasonic ranging channel.
- On request it configures a trigger pin as output and an echo pin as input, then emits a trigger pulse.
- It measures the echo high time in clk cycles and reports the result, or flags a timeout.
- Sits between the processor's memory-mapped sonar register and io_pin_set; this block is the only writer of the bank's pin_num/in/val_we/mode_we.

Parameters:
CNT_W, 24, width of echo_width and internal counters
TRIG_CYCLES, 500, trigger high time in clk cycles (10 us at 50 MHz); legal range 1..2^CNT_W-1
TIMEOUT_CYCLES, 1500000, max cycles from WAIT_RISE entry to echo fall (30 ms); must be < 2^CNT_W
PING_PERIOD, 3000000, auto-ping interval (optional feature only)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle ping request; ignored while busy=1
trig_sel  in  3  trigger pin index, latched on accepted start
echo_sel  in  3  echo pin index, latched on accepted start
pins_in  in  8  io_pin_set.out (pin readback, asynchronous to clk)
pin_num  out  3  io_pin_set pin select
pin_data  out  1  io_pin_set write data (in)
val_we  out  1  io_pin_set value write enable
mode_we  out  1  io_pin_set mode write enable (1=output, 0=input)
busy  out  1  high from accepted start until the DONE cycle inclusive
done  out  1  one-cycle pulse, result valid
timeout  out  1  sticky status of last ping; 1 = no complete echo
echo_width  out  CNT_W  last measured echo high time in cycles, held until next done

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0; synchroniser flops 0. The GPIO bank is not reset here; trig pin level after a mid-ping reset is undefined until the next ping reconfigures it.
- Echo path: pins_in[echo_sel_q] passes through a 2-flop synchroniser; all echo decisions use the synced bit (2-cycle latency).
- At most one of val_we/mode_we is asserted per cycle. The bank registers on the falling edge, so a write takes effect mid-cycle.
- States:
  - IDLE: start=1 latches trig_sel/echo_sel, clears counters, goes to CFG_TRIG. If trig_sel==echo_sel, goes to DONE with timeout=1 and echo_width=0.
  - CFG_TRIG (1 cycle): pin_num=trig, pin_data=1, mode_we=1.
  - CFG_ECHO (1 cycle): pin_num=echo, pin_data=0, mode_we=1.
  - TRIG_HI (TRIG_CYCLES cycles): first cycle drives pin_num=trig, pin_data=1, val_we=1; the cycle counter then runs.
  - TRIG_LO (1 cycle): pin_num=trig, pin_data=0, val_we=1. The trig pin is therefore high for exactly TRIG_CYCLES cycles.
  - WAIT_RISE: timeout counter starts at 0 on entry and increments every cycle. Synced echo=1 goes to MEASURE with width=1.
  - MEASURE: width increments each cycle while synced echo=1; synced echo=0 goes to DONE with timeout=0 and echo_width=width.
  - Timeout counter: keeps running through WAIT_RISE and MEASURE. Reaching TIMEOUT_CYCLES in either state goes to DONE with timeout=1 and echo_width=0.
  - DONE (1 cycle): done=1, busy=1, then IDLE.
- Simultaneous events:
  - Echo fall and timeout in the same cycle: echo fall wins (valid result).
  - start during busy: dropped, no queueing.
  - start in the DONE cycle: dropped.
  - Echo already high in WAIT_RISE: measured from the first synced-high cycle.
- Width: counters saturate at 2^CNT_W-1 and never wrap.
- Outputs pin_num/pin_data are 0 when no write enable is active.

Optional Feature:
- Macro: SONAR_AUTOPING_EN.
- Defined: adds input auto_en (1 bit). While auto_en=1, an internal CNT_W period counter issues an internal start every PING_PERIOD cycles, measured start-to-start. The pin indices are taken from trig_sel/echo_sel at that moment. An internal start that lands while busy is deferred to the first IDLE cycle. An external start also resets the period counter.
- Undefined: no auto_en port; pings occur only on external start.

Decomposition:
- Package sonar_pkg holds:
  - the state encoding (IDLE, CFG_TRIG, CFG_ECHO, TRIG_HI, TRIG_LO, WAIT_RISE, MEASURE, DONE);
  - the default TRIG_CYCLES/TIMEOUT_CYCLES/PING_PERIOD constants;
  - the mode encoding constants (MODE_IN=0, MODE_OUT=1).
- One sub-module: sonar_sync2, a 2-flop synchroniser with async active-low reset, used for the echo bit.

Test Plan (TRIG_CYCLES=4, TIMEOUT_CYCLES=100, CNT_W=8, bench models the pin bank plus an echo responder):
- Nominal ping: start, trig=2, echo=5; echo goes high 10 cycles after trig falls, for 37 cycles. Expect the mode writes in order (pin2=1, pin5=0), trig high for exactly 4 cycles, done once, timeout=0, echo_width=37, busy cleared the cycle after done.
- No echo: responder silent. Expect done exactly 100 cycles after WAIT_RISE entry, timeout=1, echo_width=0.
- Echo stuck high: echo rises 5 cycles into WAIT_RISE and never falls. Expect timeout=1, echo_width=0, done at timeout count 100.
- Same-pin request and busy drop: trig=echo=3 gives done 1 cycle after start with timeout=1 and zero bank writes. A second start mid-MEASURE leaves the result unaffected and produces only one done.
- Reset mid-TRIG_HI: drive reset=0 asynchronously. Expect busy/done/timeout/echo_width=0 and write enables 0 immediately. A new start after release completes a nominal ping correctly.
- SONAR_AUTOPING_EN with PING_PERIOD=300 and auto_en=1: done pulses exactly 300 cycles apart over 3 pings. With auto_en=0, no further pings occur.
